// File: rtl/scr1_tb_ahb_result_mon.sv
// Passive AHB data-bus monitor: tracks the address/data pipeline, decodes the
// tohost result word and keeps cycle, transfer and error-response counters.
module scr1_tb_ahb_result_mon #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_F000,
  parameter int unsigned TIMEOUT     = 2_000_000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       dmem_htrans,
  input  logic [31:0]      dmem_haddr,
  input  logic             dmem_hwrite,
  input  logic [2:0]       dmem_hsize,
  input  logic [31:0]      dmem_hwdata,
  input  logic             dmem_hready,
  input  logic             dmem_hresp,
  output logic             done,
  output logic             pass,
  output logic [30:0]      fail_code,
  output logic             timeout,
  output logic [31:0]      cycle_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_TMO  = 2'd3
  } state_e;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             dp_vld_q, dp_vld_d;
  logic [31:2]      dp_addr_q, dp_addr_d;
  logic             dp_write_q, dp_write_d;
  logic [2:0]       dp_size_q, dp_size_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [30:0]      fail_code_q, fail_code_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic run;
  logic addr_acc;
  logic dp_cmpl;
  logic is_tohost;
  logic snoop;
  logic result_hit;
  logic tmo_hit;
  logic unused_bus_bits;

  // Word-granular address match: the two byte-lane bits and HTRANS[0] carry no meaning here.
  assign unused_bus_bits = ^{dmem_htrans[0], dmem_haddr[1:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign addr_acc   = dmem_htrans[1] & dmem_hready;
  assign dp_cmpl    = dp_vld_q & dmem_hready;
  assign is_tohost  = dp_write_q && (dp_addr_q == TOHOST_ADDR[31:2]) &&
                      (dp_size_q == 3'd2) && !dmem_hresp;
  assign snoop      = run & ~start;
  assign result_hit = snoop & dp_cmpl & is_tohost;
  // A result landing on the last watchdog cycle takes precedence over the timeout.
  assign tmo_hit    = snoop & (cycle_cnt_q == TMO_LAST) & ~result_hit;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (result_hit)   state_d = S_DONE;
      else if (tmo_hit) state_d = S_TMO;
    end
  end

  // FSM: outputs
  always_comb begin
    run       = (state_q == S_RUN);
    dbg_state = state_q;
  end

  // Bus pipeline tracking runs in every state so a later start sees a coherent pipeline.
  always_comb begin
    dp_vld_d   = dp_vld_q;
    dp_addr_d  = dp_addr_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    if (addr_acc) begin
      dp_vld_d   = 1'b1;
      dp_addr_d  = dmem_haddr[31:2];
      dp_write_d = dmem_hwrite;
      dp_size_d  = dmem_hsize;
    end else if (dp_cmpl) begin
      dp_vld_d   = 1'b0;
    end
  end

  always_comb begin
    done_d      = done_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;
    timeout_d   = timeout_q;
    cycle_cnt_d = cycle_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (start) begin
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_code_d = '0;
      timeout_d   = 1'b0;
      cycle_cnt_d = '0;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      err_cnt_d   = '0;
    end else if (run) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (dp_cmpl) begin
        if (dp_write_q) wr_cnt_d = sat_inc(wr_cnt_q);
        else            rd_cnt_d = sat_inc(rd_cnt_q);
        if (dmem_hresp) err_cnt_d = sat_inc(err_cnt_q);
      end
      if (result_hit) begin
        done_d      = 1'b1;
        pass_d      = (dmem_hwdata == 32'd1);
        fail_code_d = dmem_hwdata[31:1];
      end
      if (tmo_hit) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_vld_q    <= 1'b0;
      dp_addr_q   <= '0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= '0;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      dp_vld_q    <= dp_vld_d;
      dp_addr_q   <= dp_addr_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
      timeout_q   <= timeout_d;
      cycle_cnt_q <= cycle_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_scr1_tb_ahb_result_mon.sv
// Bench for scr1_tb_ahb_result_mon: three instances (default, short watchdog,
// narrow counters) share one snooped bus; each is started independently.
module tb_scr1_tb_ahb_result_mon;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0, start_f = 1'b0, start_c = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [31:0] hwdata = '0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  logic        m_done, m_pass, m_timeout;
  logic [30:0] m_fail_code;
  logic [31:0] m_cycle_cnt;
  logic [15:0] m_wr_cnt, m_rd_cnt, m_err_cnt;
  logic [1:0]  m_state;

  logic        f_done, f_pass, f_timeout;
  logic [30:0] f_fail_code;
  logic [31:0] f_cycle_cnt;
  logic [15:0] f_wr_cnt, f_rd_cnt, f_err_cnt;
  logic [1:0]  f_state;

  logic        c_done, c_pass, c_timeout;
  logic [30:0] c_fail_code;
  logic [31:0] c_cycle_cnt;
  logic [3:0]  c_wr_cnt, c_rd_cnt, c_err_cnt;
  logic [1:0]  c_state;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int start_tick = 0;

  // transfer list consumed by drive_xfers
  int          x_n;
  logic [31:0] x_addr[32];
  logic        x_write[32];
  logic [2:0]  x_size[32];
  logic [31:0] x_data[32];
  logic        x_resp[32];
  int          x_wait[32];
  int          x_done_tick[32];

  scr1_tb_ahb_result_mon #(.TOHOST_ADDR(32'h0000_F000), .TIMEOUT(100), .CNT_W(16)) dut_m (
    .clk(clk), .rst(rst), .start(start_m),
    .dmem_htrans(htrans), .dmem_haddr(haddr), .dmem_hwrite(hwrite), .dmem_hsize(hsize),
    .dmem_hwdata(hwdata), .dmem_hready(hready), .dmem_hresp(hresp),
    .done(m_done), .pass(m_pass), .fail_code(m_fail_code), .timeout(m_timeout),
    .cycle_cnt(m_cycle_cnt), .wr_cnt(m_wr_cnt), .rd_cnt(m_rd_cnt), .err_cnt(m_err_cnt),
    .dbg_state(m_state));

  scr1_tb_ahb_result_mon #(.TOHOST_ADDR(32'h0000_F000), .TIMEOUT(50), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst), .start(start_f),
    .dmem_htrans(htrans), .dmem_haddr(haddr), .dmem_hwrite(hwrite), .dmem_hsize(hsize),
    .dmem_hwdata(hwdata), .dmem_hready(hready), .dmem_hresp(hresp),
    .done(f_done), .pass(f_pass), .fail_code(f_fail_code), .timeout(f_timeout),
    .cycle_cnt(f_cycle_cnt), .wr_cnt(f_wr_cnt), .rd_cnt(f_rd_cnt), .err_cnt(f_err_cnt),
    .dbg_state(f_state));

  scr1_tb_ahb_result_mon #(.TOHOST_ADDR(32'h0000_F000), .TIMEOUT(2_000_000), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start_c),
    .dmem_htrans(htrans), .dmem_haddr(haddr), .dmem_hwrite(hwrite), .dmem_hsize(hsize),
    .dmem_hwdata(hwdata), .dmem_hready(hready), .dmem_hresp(hresp),
    .done(c_done), .pass(c_pass), .fail_code(c_fail_code), .timeout(c_timeout),
    .cycle_cnt(c_cycle_cnt), .wr_cnt(c_wr_cnt), .rd_cnt(c_rd_cnt), .err_cnt(c_err_cnt),
    .dbg_state(c_state));

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit expired");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    tick_cnt++;
  endtask

  task automatic bus_idle();
    htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = '0; hready = 1'b1; hresp = 1'b0;
  endtask

  task automatic pulse_start(input int which);
    bus_idle();
    if (which == 0) start_m = 1'b1;
    else if (which == 1) start_f = 1'b1;
    else start_c = 1'b1;
    tick();
    start_m = 1'b0; start_f = 1'b0; start_c = 1'b0;
    start_tick = tick_cnt;
  endtask

  task automatic set_xfer(input int i, input logic [31:0] a, input logic w, input logic [2:0] s,
                          input logic [31:0] d, input logic r, input int ws);
    x_addr[i] = a; x_write[i] = w; x_size[i] = s; x_data[i] = d; x_resp[i] = r; x_wait[i] = ws;
  endtask

  // Pipelined AHB master: address phase of i overlaps data phase of i-1.
  task automatic drive_xfers();
    for (int i = 0; i <= x_n; i++) begin
      if (i < x_n) begin
        htrans = 2'b10; haddr = x_addr[i]; hwrite = x_write[i]; hsize = x_size[i];
      end else begin
        htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = '0;
      end
      if (i > 0) begin
        hwdata = x_data[i-1];
        for (int w = 0; w < x_wait[i-1]; w++) begin
          hready = 1'b0; hresp = 1'b0; tick();
        end
        hready = 1'b1; hresp = x_resp[i-1]; tick();
        x_done_tick[i-1] = tick_cnt;
      end else begin
        hready = 1'b1; hresp = 1'b0; tick();
      end
    end
    bus_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (3) tick();
    checks++; if (m_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0d exp=0", m_done); end
    checks++; if (m_pass !== 1'b0 || m_fail_code !== 31'd0 || m_timeout !== 1'b0) begin
      failures++; $display("FAIL rst_result got pass=%0d fc=%0d tmo=%0d exp=0", m_pass, m_fail_code, m_timeout); end
    checks++; if (m_cycle_cnt !== 32'd0 || m_wr_cnt !== 16'd0 || m_rd_cnt !== 16'd0 || m_err_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_counters got cyc=%0d wr=%0d rd=%0d err=%0d exp=0", m_cycle_cnt, m_wr_cnt, m_rd_cnt, m_err_cnt); end
    checks++; if (m_state !== 2'd0 || f_state !== 2'd0 || c_state !== 2'd0) begin
      failures++; $display("FAIL rst_state got m=%0d f=%0d c=%0d exp=0", m_state, f_state, c_state); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_pass();
    pulse_start(0);
    checks++; if (m_state !== 2'd1) begin failures++; $display("FAIL t1_run got=%0d exp=1", m_state); end
    x_n = 4;
    for (int i = 0; i < 3; i++) set_xfer(i, 32'h100, 1'b1, 3'd2, $urandom, 1'b0, 0);
    set_xfer(3, 32'hF000, 1'b1, 3'd2, 32'd1, 1'b0, 0);
    drive_xfers();
    checks++; if (m_done !== 1'b1 || m_pass !== 1'b1) begin
      failures++; $display("FAIL t1_pass got done=%0d pass=%0d exp done=1 pass=1", m_done, m_pass); end
    checks++; if (m_wr_cnt !== 16'd4 || m_rd_cnt !== 16'd0) begin
      failures++; $display("FAIL t1_counts got wr=%0d rd=%0d exp wr=4 rd=0", m_wr_cnt, m_rd_cnt); end
    checks++; if (m_cycle_cnt !== 32'd5 || m_state !== 2'd2) begin
      failures++; $display("FAIL t1_cycle got cyc=%0d st=%0d exp cyc=5 st=2", m_cycle_cnt, m_state); end
  endtask

  task automatic test_wait_states();
    pulse_start(0);
    htrans = 2'b10; haddr = 32'hF000; hwrite = 1'b1; hsize = 3'd2; hready = 1'b1;
    tick();
    // address bus changes under the stall; the captured phase must not
    htrans = 2'b00; haddr = 32'h100; hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0000_000B;
    for (int w = 0; w < 3; w++) begin
      hready = 1'b0;
      tick();
      checks++; if (m_done !== 1'b0) begin failures++; $display("FAIL t2_early_done w=%0d got=%0d exp=0", w, m_done); end
    end
    hready = 1'b1;
    tick();
    bus_idle();
    checks++; if (m_done !== 1'b1 || m_pass !== 1'b0) begin
      failures++; $display("FAIL t2_result got done=%0d pass=%0d exp done=1 pass=0", m_done, m_pass); end
    checks++; if (m_fail_code !== 31'd5) begin failures++; $display("FAIL t2_fail_code got=%0d exp=5", m_fail_code); end
    checks++; if (m_wr_cnt !== 16'd1 || m_cycle_cnt !== 32'd5) begin
      failures++; $display("FAIL t2_counts got wr=%0d cyc=%0d exp wr=1 cyc=5", m_wr_cnt, m_cycle_cnt); end
  endtask

  task automatic test_timeout();
    int hit_at;
    pulse_start(0);
    x_n = 1;
    set_xfer(0, 32'hF000, 1'b1, 3'd0, 32'd1, 1'b0, 0);
    drive_xfers();
    hit_at = -1;
    for (int k = 0; k < 200 && hit_at < 0; k++) begin
      if (m_timeout === 1'b1) hit_at = tick_cnt - start_tick;
      else tick();
    end
    checks++; if (hit_at != 100) begin failures++; $display("FAIL t3_tmo_cycle got=%0d exp=100", hit_at); end
    checks++; if (m_done !== 1'b0 || m_timeout !== 1'b1) begin
      failures++; $display("FAIL t3_flags got done=%0d tmo=%0d exp done=0 tmo=1", m_done, m_timeout); end
    checks++; if (m_cycle_cnt !== 32'd100 || m_wr_cnt !== 16'd1) begin
      failures++; $display("FAIL t3_counts got cyc=%0d wr=%0d exp cyc=100 wr=1", m_cycle_cnt, m_wr_cnt); end
    repeat (5) tick();
    checks++; if (m_cycle_cnt !== 32'd100 || m_state !== 2'd3) begin
      failures++; $display("FAIL t3_frozen got cyc=%0d st=%0d exp cyc=100 st=3", m_cycle_cnt, m_state); end
  endtask

  task automatic test_back_to_back();
    pulse_start(0);
    x_n = 3;
    set_xfer(0, 32'h200, 1'b0, 3'd2, 32'h0, 1'b0, 0);
    set_xfer(1, 32'hF000, 1'b1, 3'd2, 32'd1, 1'b0, 0);
    set_xfer(2, 32'h204, 1'b0, 3'd2, 32'h0, 1'b1, 0);
    drive_xfers();
    checks++; if (m_done !== 1'b1 || m_pass !== 1'b1) begin
      failures++; $display("FAIL t4_pass got done=%0d pass=%0d exp 1 1", m_done, m_pass); end
    checks++; if (m_rd_cnt !== 16'd1 || m_err_cnt !== 16'd0 || m_wr_cnt !== 16'd1) begin
      failures++; $display("FAIL t4_counts got rd=%0d err=%0d wr=%0d exp rd=1 err=0 wr=1", m_rd_cnt, m_err_cnt, m_wr_cnt); end
  endtask

  task automatic test_timeout_race();
    pulse_start(1);
    repeat (48) tick();
    x_n = 1;
    set_xfer(0, 32'hF000, 1'b1, 3'd2, 32'd1, 1'b0, 0);
    drive_xfers();
    checks++; if (f_done !== 1'b1 || f_pass !== 1'b1 || f_timeout !== 1'b0) begin
      failures++; $display("FAIL t5_race got done=%0d pass=%0d tmo=%0d exp 1 1 0", f_done, f_pass, f_timeout); end
    checks++; if (f_cycle_cnt !== 32'd50) begin failures++; $display("FAIL t5_cycle got=%0d exp=50", f_cycle_cnt); end
    pulse_start(1);
    repeat (49) tick();
    drive_xfers();
    checks++; if (f_done !== 1'b0 || f_timeout !== 1'b1) begin
      failures++; $display("FAIL t5_late got done=%0d tmo=%0d exp done=0 tmo=1", f_done, f_timeout); end
    checks++; if (f_cycle_cnt !== 32'd50 || f_wr_cnt !== 16'd0) begin
      failures++; $display("FAIL t5_late_counts got cyc=%0d wr=%0d exp cyc=50 wr=0", f_cycle_cnt, f_wr_cnt); end
  endtask

  task automatic test_saturation();
    pulse_start(2);
    x_n = 20;
    for (int i = 0; i < 20; i++) set_xfer(i, 32'h300 + 32'(4 * i), 1'b0, 3'd2, 32'h0, 1'b0, 0);
    drive_xfers();
    checks++; if (c_rd_cnt !== 4'd15 || c_wr_cnt !== 4'd0) begin
      failures++; $display("FAIL t6_sat got rd=%0d wr=%0d exp rd=15 wr=0", c_rd_cnt, c_wr_cnt); end
    pulse_start(2);
    checks++; if (c_rd_cnt !== 4'd0 || c_wr_cnt !== 4'd0 || c_err_cnt !== 4'd0 || c_cycle_cnt !== 32'd0) begin
      failures++; $display("FAIL t6_clear got rd=%0d wr=%0d err=%0d cyc=%0d exp 0", c_rd_cnt, c_wr_cnt, c_err_cnt, c_cycle_cnt); end
    checks++; if (c_done !== 1'b0 || c_state !== 2'd1) begin
      failures++; $display("FAIL t6_restart got done=%0d st=%0d exp done=0 st=1", c_done, c_state); end
  endtask

  task automatic test_start_pending();
    pulse_start(0);
    htrans = 2'b10; haddr = 32'hF000; hwrite = 1'b1; hsize = 3'd2; hready = 1'b1;
    tick();
    htrans = 2'b00; hwdata = 32'd1; hready = 1'b1; start_m = 1'b1;
    tick();
    start_m = 1'b0;
    bus_idle();
    checks++; if (m_done !== 1'b0 || m_wr_cnt !== 16'd0 || m_cycle_cnt !== 32'd0 || m_state !== 2'd1) begin
      failures++; $display("FAIL start_pending got done=%0d wr=%0d cyc=%0d st=%0d exp 0 0 0 1", m_done, m_wr_cnt, m_cycle_cnt, m_state); end
    tick();
    checks++; if (m_cycle_cnt !== 32'd1) begin failures++; $display("FAIL start_pending_cyc got=%0d exp=1", m_cycle_cnt); end
  endtask

  task automatic test_reset_mid();
    pulse_start(0);
    htrans = 2'b10; haddr = 32'hF000; hwrite = 1'b1; hsize = 3'd2; hready = 1'b1;
    tick();
    htrans = 2'b00; hready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; start_m = 1'b1;
    tick();
    start_m = 1'b0; hready = 1'b1; hwdata = 32'd1;
    tick();
    checks++; if (m_done !== 1'b0 || m_wr_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_mid_dropped got done=%0d wr=%0d exp 0 0", m_done, m_wr_cnt); end
    x_n = 1;
    set_xfer(0, 32'hF000, 1'b1, 3'd2, 32'd1, 1'b0, 1);
    drive_xfers();
    checks++; if (m_done !== 1'b1 || m_pass !== 1'b1 || m_wr_cnt !== 16'd1) begin
      failures++; $display("FAIL rst_mid_restart got done=%0d pass=%0d wr=%0d exp 1 1 1", m_done, m_pass, m_wr_cnt); end
  endtask

  // Reference model: walk the transfer list in bus order; the first clean
  // word write to tohost ends the run, later transfers are ignored.
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic        e_done, e_pass;
      logic [30:0] e_fc;
      int          e_wr, e_rd, e_err, e_cyc;
      pulse_start(0);
      x_n = $urandom_range(1, 8);
      for (int i = 0; i < x_n; i++) begin
        int sel;
        logic [31:0] a;
        sel = $urandom_range(0, 3);
        if (sel == 0) a = 32'hF000;
        else if (sel == 1) a = 32'hF000 | 32'($urandom_range(0, 3));
        else if (sel == 2) a = 32'h100 + 32'(4 * $urandom_range(0, 15));
        else a = 32'hF004;
        set_xfer(i, a, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'd2,
                 ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom,
                 ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
      end
      drive_xfers();
      e_done = 1'b0; e_pass = 1'b0; e_fc = '0; e_wr = 0; e_rd = 0; e_err = 0;
      e_cyc = tick_cnt - start_tick;
      for (int i = 0; i < x_n; i++) begin
        if (!e_done) begin
          if (x_write[i]) e_wr++; else e_rd++;
          if (x_resp[i]) e_err++;
          if (x_write[i] && (x_addr[i] >> 2) == (32'hF000 >> 2) && x_size[i] == 3'd2 && !x_resp[i]) begin
            e_done = 1'b1;
            e_pass = (x_data[i] == 32'd1);
            e_fc = x_data[i][31:1];
            e_cyc = x_done_tick[i] - start_tick;
          end
        end
      end
      checks++; if (m_done !== e_done || m_timeout !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_done got done=%0d tmo=%0d exp done=%0d tmo=0", it, m_done, m_timeout, e_done); end
      checks++; if (m_done === 1'b1 && (m_pass !== e_pass || (!e_pass && m_fail_code !== e_fc))) begin
        failures++; $display("FAIL rnd%0d_result got pass=%0d fc=%0h exp pass=%0d fc=%0h", it, m_pass, m_fail_code, e_pass, e_fc); end
      checks++; if (m_wr_cnt !== 16'(e_wr) || m_rd_cnt !== 16'(e_rd) || m_err_cnt !== 16'(e_err)) begin
        failures++; $display("FAIL rnd%0d_counts got wr=%0d rd=%0d err=%0d exp wr=%0d rd=%0d err=%0d",
                             it, m_wr_cnt, m_rd_cnt, m_err_cnt, e_wr, e_rd, e_err); end
      checks++; if (m_cycle_cnt !== 32'(e_cyc)) begin
        failures++; $display("FAIL rnd%0d_cycle got=%0d exp=%0d", it, m_cycle_cnt, e_cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_timeout_race();
    test_saturation();
    test_start_pending();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
